present_enc_ctrl: RTL and testbench

Iterative PRESENT-80 encryption engine. One round per clock, with the key schedule run in lock-step. An FSM sequences a start/busy/done handshake around a 64-bit state register and an 80-bit key register. It sits beside gen_round_keyz as the block that owns round counting and the final key whitening. It presents a single-request encrypt interface to the surrounding design.

---
 rtl/present_enc_ctrl.sv | 153 +++++++++++++++
 tb/tb_present_enc_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/present_enc_ctrl.sv
// Iterative PRESENT-80 encryptor: one round per clock, key schedule in lock-step, start/busy/done handshake.
// Define PRESENT_RK_TAP_EN to expose the live round key and round index for cross-checking.
module present_enc_ctrl #(
  parameter int NUM_ROUNDS = 31,
  parameter int CTR_W      = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [79:0]        key,
  input  logic [63:0]        data_in,
  output logic [63:0]        data_out,
  output logic               busy,
  output logic               done
`ifdef PRESENT_RK_TAP_EN
  ,
  output logic [63:0]        round_key,
  output logic [CTR_W-1:0]   round_idx
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FINAL = 2'd2
  } fsm_e;

  localparam logic [CTR_W-1:0] LAST_CNT = CTR_W'(NUM_ROUNDS);
  localparam logic [CTR_W-1:0] CNT_ONE  = CTR_W'(1);

  fsm_e             fsm_q, fsm_d;
  logic [63:0]      state_q, state_d;
  logic [79:0]      key_q, key_d;
  logic [CTR_W-1:0] cnt_q, cnt_d;
  logic [63:0]      data_out_q, data_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  4'hF: y = 4'h2;
      default: y = 4'h0;
    endcase
    return y;
  endfunction

  function automatic logic [63:0] sbox_layer(input logic [63:0] s);
    logic [63:0] o;
    o = 64'd0;
    for (int n = 0; n < 16; n++) begin
      o[4*n +: 4] = sbox4(s[4*n +: 4]);
    end
    return o;
  endfunction

  function automatic logic [63:0] p_layer(input logic [63:0] s);
    logic [63:0] p;
    p = 64'd0;
    for (int i = 0; i < 63; i++) begin
      p[(i * 16) % 63] = s[i];
    end
    p[63] = s[63];
    return p;
  endfunction

  // rc is the low five bits of the round counter, XORed into key bits 19:15.
  function automatic logic [79:0] key_update(input logic [79:0] k, input logic [4:0] rc);
    logic [79:0] r;
    r          = {k[18:0], k[79:19]};
    r[79:76]   = sbox4(r[79:76]);
    r[19:15]   = r[19:15] ^ rc;
    return r;
  endfunction

  // Next-state and datapath selection for the IDLE/RUN/FINAL sequence.
  always_comb begin
    fsm_d      = fsm_q;
    state_d    = state_q;
    key_d      = key_q;
    cnt_d      = cnt_q;
    data_out_d = data_out_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (fsm_q)
      ST_IDLE: begin
        if (start) begin
          state_d = data_in;
          key_d   = key;
          cnt_d   = CNT_ONE;
          busy_d  = 1'b1;
          fsm_d   = ST_RUN;
        end else begin
          fsm_d   = ST_IDLE;
        end
      end
      ST_RUN: begin
        state_d = p_layer(sbox_layer(state_q ^ key_q[79:16]));
        key_d   = key_update(key_q, 5'(cnt_q));
        // Counter parks at NUM_ROUNDS on the exit edge so it never wraps.
        if (cnt_q == LAST_CNT) begin
          fsm_d = ST_FINAL;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_FINAL: begin
        data_out_d = state_q ^ key_q[79:16];
        done_d     = 1'b1;
        busy_d     = 1'b0;
        fsm_d      = ST_IDLE;
      end
      default: begin
        fsm_d  = ST_IDLE;
        busy_d = 1'b0;
      end
    endcase
  end

  // State register with synchronous reset taking priority over any job in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      fsm_q      <= ST_IDLE;
      state_q    <= 64'd0;
      key_q      <= 80'd0;
      cnt_q      <= {CTR_W{1'b0}};
      data_out_q <= 64'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      state_q    <= state_d;
      key_q      <= key_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign data_out = data_out_q;
  assign busy     = busy_q;
  assign done     = done_q;

`ifdef PRESENT_RK_TAP_EN
  assign round_key = key_q[79:16];
  assign round_idx = cnt_q;
`endif

endmodule

// File: tb/tb_present_enc_ctrl.sv
// Self-checking bench for present_enc_ctrl: known-answer vectors, random jobs against a
// behavioural PRESENT-80 model, handshake timing, back-to-back, busy-ignore and mid-job reset.
module tb_present_enc_ctrl;

  localparam int NR  = 31;
  localparam int LAT = NR + 1;
  localparam logic [63:0] SBOX_TBL = 64'h21748FE3DA09B65C;

  logic        clock;
  logic        reset;
  logic        start;
  logic [79:0] key;
  logic [63:0] data_in;
  logic [63:0] data_out;
  logic        busy;
  logic        done;
`ifdef PRESENT_RK_TAP_EN
  logic [63:0] round_key;
  logic [4:0]  round_idx;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  present_enc_ctrl #(.NUM_ROUNDS(NR), .CTR_W(5)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .key      (key),
    .data_in  (data_in),
    .data_out (data_out),
    .busy     (busy),
    .done     (done)
`ifdef PRESENT_RK_TAP_EN
    ,
    .round_key(round_key),
    .round_idx(round_idx)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] ref_s(input logic [3:0] x);
    logic [63:0] tbl;
    tbl = SBOX_TBL;
    return tbl[4*x +: 4];
  endfunction

  // Reference PRESENT-80: NR rounds of addRoundKey/sBox/pLayer then final whitening.
  function automatic logic [63:0] present_ref(input logic [79:0] k_in, input logic [63:0] p);
    logic [79:0] k;
    logic [63:0] s, t;
    k = k_in;
    s = p;
    for (int r = 1; r <= NR; r++) begin
      s = s ^ k[79:16];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = ref_s(s[4*n +: 4]);
      t = 64'd0;
      for (int b = 0; b < 64; b++) t[(b == 63) ? 63 : ((16 * b) % 63)] = s[b];
      s = t;
      k = (k << 61) | (k >> 19);
      k[79:76] = ref_s(k[79:76]);
      k[19:15] = k[19:15] ^ 5'(r);
    end
    return s ^ k[79:16];
  endfunction

  function automatic logic [79:0] rand80();
    return {$urandom, $urandom, 16'($urandom)};
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Pulses start with the given operands and waits (bounded) for done.
  task automatic run_job(input logic [79:0] k, input logic [63:0] d,
                         output logic [63:0] res, output int lat, output int bcnt,
                         output bit timed_out);
    key = k; data_in = d; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0; bcnt = 0;
    while (!done && lat < 200) begin
      if (busy) bcnt++;
      tick();
      lat++;
    end
    timed_out = !done;
    res = data_out;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; key = 80'd0; data_in = 64'd0;
    tick(); tick();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_tests++; if (data_out !== 64'd0) begin n_fail++; $display("FAIL reset_data_out: got %h want 0", data_out); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_vectors();
    logic [79:0] kv [3];
    logic [63:0] dv [3];
    logic [63:0] ev [3];
    logic [63:0] res, held;
    int lat, bcnt;
    bit to;
    kv[0] = 80'h0;                    dv[0] = 64'h0;                ev[0] = 64'h5579C1387B228445;
    kv[1] = 80'hFFFFFFFFFFFFFFFFFFFF; dv[1] = 64'h0;                ev[1] = 64'hE72C46C0F5945049;
    kv[2] = 80'h0;                    dv[2] = 64'hFFFFFFFFFFFFFFFF; ev[2] = 64'hA112FFC72F68417B;
    for (int v = 0; v < 3; v++) begin
      run_job(kv[v], dv[v], res, lat, bcnt, to);
      n_tests++; if (to) begin n_fail++; $display("FAIL kat%0d_timeout: no done within 200 cycles", v); end
      n_tests++; if (res !== ev[v]) begin n_fail++; $display("FAIL kat%0d_data: got %h want %h", v, res, ev[v]); end
      n_tests++; if (lat !== LAT) begin n_fail++; $display("FAIL kat%0d_latency: got %0d want %0d", v, lat, LAT); end
      n_tests++; if (bcnt !== LAT) begin n_fail++; $display("FAIL kat%0d_busy_cycles: got %0d want %0d", v, bcnt, LAT); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL kat%0d_busy_at_done: got %b want 0", v, busy); end
      held = data_out;
      key = rand80(); data_in = rand64();
      for (int i = 0; i < 3; i++) begin
        tick();
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL kat%0d_done_pulse: done high %0d cycles after pulse", v, i + 1); end
        n_tests++; if (data_out !== ev[v]) begin n_fail++; $display("FAIL kat%0d_hold: got %h want %h", v, data_out, ev[v]); end
      end
      if (held !== ev[v]) begin end
    end
  endtask

  task automatic test_random();
    logic [79:0] k;
    logic [63:0] d, res, exp;
    int lat, bcnt;
    bit to;
    for (int j = 0; j < 8; j++) begin
      k = rand80(); d = rand64();
      exp = present_ref(k, d);
      run_job(k, d, res, lat, bcnt, to);
      n_tests++; if (to) begin n_fail++; $display("FAIL rand%0d_timeout: no done within 200 cycles", j); end
      n_tests++; if (res !== exp) begin n_fail++; $display("FAIL rand%0d_data: got %h want %h", j, res, exp); end
      n_tests++; if (lat !== LAT) begin n_fail++; $display("FAIL rand%0d_latency: got %0d want %0d", j, lat, LAT); end
      repeat ($urandom_range(3, 0)) tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] res;
    int lat, bcnt, gap;
    bit to;
    run_job(80'hFFFFFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, res, lat, bcnt, to);
    n_tests++; if (res !== 64'h3333DCD3213210D2) begin n_fail++; $display("FAIL b2b_first: got %h want 3333dcd3213210d2", res); end
    start = 1'b1;
    gap = 0;
    do begin
      tick();
      gap++;
    end while (!done && gap < 200);
    n_tests++; if (gap !== LAT + 1) begin n_fail++; $display("FAIL b2b_gap: got %0d want %0d", gap, LAT + 1); end
    n_tests++; if (data_out !== 64'h3333DCD3213210D2) begin n_fail++; $display("FAIL b2b_second: got %h want 3333dcd3213210d2", data_out); end
    start = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0; tick();
  endtask

  task automatic test_busy_ignore();
    int lat;
    key = 80'd0; data_in = 64'd0; start = 1'b1;
    tick();
    lat = 0;
    while (!done && lat < 200) begin
      start = 1'($urandom);
      key = rand80(); data_in = rand64();
      tick();
      lat++;
    end
    start = 1'b0;
    n_tests++; if (lat !== LAT) begin n_fail++; $display("FAIL busy_ignore_latency: got %0d want %0d", lat, LAT); end
    n_tests++; if (data_out !== 64'h5579C1387B228445) begin n_fail++; $display("FAIL busy_ignore_data: got %h want 5579c1387b228445", data_out); end
    tick();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_ignore_idle: busy got %b want 0", busy); end
  endtask

  task automatic test_mid_reset();
    logic [79:0] k;
    logic [63:0] d, res, exp;
    int lat, bcnt;
    bit to, saw_done;
    key = rand80(); data_in = rand64(); start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b want 0", done); end
    n_tests++; if (data_out !== 64'd0) begin n_fail++; $display("FAIL midrst_data_out: got %h want 0", data_out); end
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) saw_done = 1'b1;
    end
    n_tests++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL midrst_ghost: got activity %b want 0", saw_done); end
    k = rand80(); d = rand64();
    exp = present_ref(k, d);
    run_job(k, d, res, lat, bcnt, to);
    n_tests++; if (res !== exp || to) begin n_fail++; $display("FAIL midrst_restart: got %h want %h", res, exp); end
    n_tests++; if (lat !== LAT) begin n_fail++; $display("FAIL midrst_latency: got %0d want %0d", lat, LAT); end
  endtask

`ifdef PRESENT_RK_TAP_EN
  task automatic test_tap();
    int w;
    key = 80'd0; data_in = 64'd0; start = 1'b1;
    tick();
    start = 1'b0;
    n_tests++; if (round_key !== 64'd0) begin n_fail++; $display("FAIL tap_round_key: got %h want 0", round_key); end
    n_tests++; if (round_idx !== 5'd1) begin n_fail++; $display("FAIL tap_round_idx: got %0d want 1", round_idx); end
    w = 0;
    while (!done && w < 200) begin tick(); w++; end
    n_tests++; if (w !== LAT) begin n_fail++; $display("FAIL tap_latency: got %0d want %0d", w, LAT); end
  endtask
`endif

  initial begin
    reset = 1'b1; start = 1'b0; key = 80'd0; data_in = 64'd0;
    tick();
    test_reset();
    test_vectors();
    test_random();
    test_back_to_back();
    test_busy_ignore();
    test_mid_reset();
`ifdef PRESENT_RK_TAP_EN
    test_tap();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
